mario_motion: RTL and testbench

MARIO_MOTION -- requirements
Module: mario_motion

---
 rtl/mario_motion.sv | 134 +++++++++++++
 tb/tb_mario_motion.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mario_motion.sv
// mario_motion: sprite position/jump physics stepped by a frame tick.
// Ports: clk, rstn (async active-low); tick frame strobe; walk/oriental horizontal request;
// jump raw button; w/h sprite size; ground_y ground surface; x/y/vy registered motion state;
// airborne and jump_state (00 GROUND, 01 RISE, 10 FALL) report the jump FSM.
// Optional feature: define JUMP_CUT_EN for variable jump height (releasing jump in RISE starts the fall).
module mario_motion #(
  parameter int X_INIT     = 32,
  parameter int Y_INIT     = 400,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 640,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int VY_MAX     = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        walk,
  input  logic        oriental,
  input  logic        jump,
  input  logic [10:0] w,
  input  logic [10:0] h,
  input  logic [10:0] ground_y,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [4:0]  vy,
  output logic        airborne,
  output logic [1:0]  jump_state
);
  localparam logic [1:0]  ST_GROUND = 2'b00;
  localparam logic [1:0]  ST_RISE   = 2'b01;
  localparam logic [1:0]  ST_FALL   = 2'b10;
  localparam logic [11:0] L_X_MIN   = 12'(X_MIN);
  localparam logic [11:0] L_X_MAX   = 12'(X_MAX);
  localparam logic [11:0] L_WALK    = 12'(WALK_SPEED);
  localparam logic [11:0] L_JUMP_V  = 12'(JUMP_V);
  localparam logic [11:0] L_GRAV    = 12'(GRAVITY);
  localparam logic [11:0] L_VY_MAX  = 12'(VY_MAX);
  logic        jump_q, jump_req, req;
  logic [11:0] x_w, y_w, vy_w, h_w, w_w, g_w;
  logic [11:0] x_lim, x_right, x_left, y_gnd, vy_sum, vy_dn;
  logic [10:0] x_n, y_n;
  logic [4:0]  vy_n;
  logic [1:0]  state_n;
  // A press landing in the tick cycle itself must still be seen by that tick.
  assign req = jump_req | (jump & ~jump_q);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      jump_q   <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      jump_q   <= jump;
      jump_req <= tick ? 1'b0 : req;
    end
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};
  assign vy_w = {7'd0, vy};
  assign h_w  = {1'b0, h};
  assign w_w  = {1'b0, w};
  assign g_w  = {1'b0, ground_y};
  // Rightmost legal left edge; a sprite wider than the screen pins to 0.
  assign x_lim   = (L_X_MAX > w_w) ? L_X_MAX - w_w : 12'd0;
  assign x_right = (x_w + L_WALK > x_lim) ? x_lim : x_w + L_WALK;
  assign x_left  = (x_w < L_X_MIN + L_WALK) ? L_X_MIN : x_w - L_WALK;
  assign x_n     = !walk ? x : 11'(oriental ? x_left : x_right);
  assign y_gnd   = (g_w > h_w) ? g_w - h_w : 12'd0;
  assign vy_sum  = vy_w + L_GRAV;
  assign vy_dn   = (vy_sum > L_VY_MAX) ? L_VY_MAX : vy_sum;
  // State register: motion state only advances on a frame tick.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      x          <= 11'(X_INIT);
      y          <= 11'(Y_INIT);
      vy         <= 5'd0;
      jump_state <= ST_GROUND;
    end else if (tick) begin
      x          <= x_n;
      y          <= y_n;
      vy         <= vy_n;
      jump_state <= state_n;
    end
  // Next-state logic for the jump FSM and its vertical datapath.
  always_comb begin
    state_n = jump_state;
    y_n     = y;
    vy_n    = vy;
    case (jump_state)
      ST_GROUND:
        if (y_w + h_w < g_w) begin
          state_n = ST_FALL;
          vy_n    = 5'd0;
        end else if (req) begin
          state_n = ST_RISE;
          vy_n    = 5'(L_JUMP_V);
        end else
          y_n = 11'(y_gnd);
      ST_RISE:
`ifdef JUMP_CUT_EN
        if (!jump) begin
          state_n = ST_FALL;
          vy_n    = 5'd0;
        end else
`endif
        if (vy_w > y_w) begin
          state_n = ST_FALL;
          y_n     = 11'd0;
          vy_n    = 5'd0;
        end else begin
          y_n = 11'(y_w - vy_w);
          if (vy_w <= L_GRAV) begin
            state_n = ST_FALL;
            vy_n    = 5'd0;
          end else
            vy_n = 5'(vy_w - L_GRAV);
        end
      ST_FALL:
        if (y_w + vy_dn + h_w >= g_w) begin
          state_n = ST_GROUND;
          y_n     = 11'(y_gnd);
          vy_n    = 5'd0;
        end else begin
          y_n  = 11'(y_w + vy_dn);
          vy_n = 5'(vy_dn);
        end
      default: begin
        state_n = ST_FALL;
        vy_n    = 5'd0;
      end
    endcase
  end
  // Output logic.
  always_comb airborne = (jump_state != ST_GROUND);
endmodule

// File: tb/tb_mario_motion.sv
// tb_mario_motion: randomized and directed checks of mario_motion against a behavioural model.
module tb_mario_motion;
  logic        clk = 0, rstn = 0, tick = 0, walk = 0, oriental = 0, jump = 0;
  logic [10:0] w = 11'd16, h = 11'd32, ground_y = 11'd432;
  logic [10:0] x, y;
  logic [4:0]  vy;
  logic        airborne;
  logic [1:0]  jump_state;
  int checks = 0, errors = 0;
  int m_x, m_y, m_vy, m_mode;
  bit m_jq, m_req;

  mario_motion dut (.clk(clk), .rstn(rstn), .tick(tick), .walk(walk), .oriental(oriental),
    .jump(jump), .w(w), .h(h), .ground_y(ground_y), .x(x), .y(y), .vy(vy),
    .airborne(airborne), .jump_state(jump_state));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"}, int'(x), m_x);
    check({tag, ".y"}, int'(y), m_y);
    check({tag, ".vy"}, int'(vy), m_vy);
    check({tag, ".state"}, int'(jump_state), m_mode);
    check({tag, ".airborne"}, int'(airborne), int'(m_mode != 0));
  endtask

  task automatic model_reset();
    m_x = 32; m_y = 400; m_vy = 0; m_mode = 0; m_jq = 0; m_req = 0;
  endtask

  // Physics as stated in plain integers; modes: 0 ground, 1 rising, 2 falling.
  task automatic model_clk();
    bit pend;
    int gy, hh, nv;
    if (!rstn) begin model_reset(); return; end
    pend = m_req || (jump && !m_jq);
    m_jq = jump;
    if (!tick) begin m_req = pend; return; end
    m_req = 0;
    gy = int'(ground_y);
    hh = int'(h);
    if (walk) begin
      if (oriental) m_x = (m_x < 2) ? 0 : m_x - 2;
      else m_x = (m_x + 2 < 640 - int'(w)) ? m_x + 2 : 640 - int'(w);
    end
    if (m_mode == 0) begin
      if (m_y + hh < gy) begin m_mode = 2; m_vy = 0; end
      else if (pend) begin m_mode = 1; m_vy = 12; end
      else m_y = gy - hh;
    end else if (m_mode == 1) begin
`ifdef JUMP_CUT_EN
      if (!jump) begin m_mode = 2; m_vy = 0; return; end
`endif
      if (m_vy > m_y) begin m_y = 0; m_vy = 0; m_mode = 2; end
      else begin
        m_y -= m_vy;
        m_vy -= 1;
        if (m_vy <= 0) begin m_vy = 0; m_mode = 2; end
      end
    end else begin
      nv = (m_vy + 1 > 8) ? 8 : m_vy + 1;
      if (m_y + nv + hh >= gy) begin m_y = gy - hh; m_vy = 0; m_mode = 0; end
      else begin m_y += nv; m_vy = nv; end
    end
  endtask

  task automatic cycle(input bit t, input string tag);
    tick = t;
    @(posedge clk);
    model_clk();
    #1;
    check_all(tag);
  endtask

  initial begin
    int min_y, rise_cnt, max_fall_vy, n;
    model_reset();
    repeat (3) cycle(1, "reset");
    @(negedge clk) rstn = 1;
    for (int i = 0; i < 10; i++) cycle(1, "idle");
    check("idle_y_400", int'(y), 400);
    check("idle_x_32", int'(x), 32);

    // Left wall: park at x=3 using a wide sprite, then walk left.
    w = 11'd637; walk = 1; oriental = 0;
    cycle(1, "to3");
    check("x_is_3", int'(x), 3);
    w = 11'd16; oriental = 1;
    cycle(1, "left1"); check("left_x1", int'(x), 1);
    cycle(1, "left2"); check("left_x0", int'(x), 0);
    cycle(1, "left3"); check("left_hold0", int'(x), 0);

    // Right wall.
    w = 11'd18; oriental = 0;
    for (int i = 0; i < 315; i++) cycle(1, "walkr");
    check("x_is_622", int'(x), 622);
    w = 11'd16;
    cycle(1, "right1"); check("right_x624", int'(x), 624);
    cycle(1, "right2"); check("right_hold624", int'(x), 624);
    walk = 0;

    // Full jump arc with jump held.
    jump = 0; cycle(0, "pre");
    jump = 1;
    min_y = 1000; rise_cnt = 0; max_fall_vy = 0; n = 0;
    do begin
      cycle(1, "arc");
      n++;
      if (jump_state == 2'b01) rise_cnt++;
      if (int'(y) < min_y) min_y = int'(y);
      if (jump_state == 2'b10 && int'(vy) > max_fall_vy) max_fall_vy = int'(vy);
    end while (jump_state != 2'b00 && n < 120);
    check("arc_bounded", int'(n < 120), 1);
    check("arc_rise_ticks", rise_cnt, 12);
    check("arc_peak", min_y, 322);
    check("arc_fall_cap", max_fall_vy, 8);
    check("arc_land_y", int'(y), 400);
    check("arc_land_state", int'(jump_state), 0);

`ifdef JUMP_CUT_EN
    jump = 0; cycle(0, "cpre");
    jump = 1; cycle(1, "cstart");
    repeat (3) cycle(1, "crise");
    jump = 0; cycle(1, "ccut");
    check("cut_y", int'(y), 367);
    check("cut_vy", int'(vy), 0);
    check("cut_state", int'(jump_state), 2);
    repeat (40) cycle(1, "cland");
`endif

    // Edge and tick together while ground drops away: falling wins.
    jump = 0; cycle(0, "epre");
    ground_y = 11'd500; jump = 1;
    cycle(1, "edge_tick");
    check("edge_fall_state", int'(jump_state), 2);
    check("edge_fall_vy", int'(vy), 0);
    repeat (30) cycle(1, "drop");
    check("drop_land", int'(y), 468);
    ground_y = 11'd432; jump = 0;
    cycle(1, "snap");
    check("snap_y", int'(y), 400);

    // Reset mid-rise.
    jump = 1; cycle(0, "rpre");
    repeat (3) cycle(1, "rrise");
    check("rrise_state", int'(jump_state), 1);
    #2 rstn = 0;
    model_reset();
    #1 check_all("async_rst");
    jump = 0;
    @(negedge clk) rstn = 1;
    cycle(1, "post_rst");
    check("post_rst_state", int'(jump_state), 0);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      int r;
      walk = 1'($urandom_range(0, 1));
      oriental = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) jump = ~jump;
      if ($urandom_range(0, 199) == 0) begin
        r = $urandom_range(0, 3);
        ground_y = (r == 0) ? 11'd432 : (r == 1) ? 11'd300 : (r == 2) ? 11'd40 : 11'd500;
      end
      if ($urandom_range(0, 299) == 0) h = $urandom_range(0, 1) ? 11'd16 : 11'd32;
      if ($urandom_range(0, 299) == 0) begin
        r = $urandom_range(0, 2);
        w = (r == 0) ? 11'd16 : (r == 1) ? 11'd32 : 11'd600;
      end
      cycle(1'($urandom_range(0, 1)), "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
